// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-requester UART tx line arbiter.
package uart_arb_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_e;

  // Requester indices on req/done/gnt
  localparam logic REQ_CMD  = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  // Default width of the shared guard/watchdog counter
  localparam int CNT_W_DEF = 18;

endpackage : uart_arb_pkg

// File: rtl/arb_cycle_timer.sv
// Clearable up-counter with a terminal-count compare. The arbiter shares one
// instance between the guard gap and the ownership watchdog, since the two
// are never active at the same time.
module arb_cycle_timer #(
  parameter int CNT_W = 18
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_val_i,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear dominates, otherwise count when enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule : arb_cycle_timer

// File: rtl/uart_tx_arbiter.sv
// Shares the serial tx pin between a command sender (0) and a data sender (1)
// with request/grant handshake, round-robin fairness, an idle guard gap after
// every release and an ownership watchdog.
// Optional build macro UART_ARB_FIXED_PRIO_EN: the data sender always wins a
// simultaneous request instead of alternating.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int GUARD_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] done,
  input  logic       tx_in0,
  input  logic       tx_in1,
  output logic [1:0] gnt,
  output logic       owner,
  output logic       busy,
  output logic       timeout,
  output logic       tx
);

  // Terminal counts: the counter starts at zero on state entry, so N cycles end at N-1
  localparam logic             GUARD_EN   = (GUARD_CYCLES > 0) ? 1'b1 : 1'b0;
  localparam logic             WD_EN      = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] GUARD_TC   = (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] TIMEOUT_TC = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};

  arb_state_e       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic             tx_q, tx_d;

  logic             pick_s;
  logic             release_s;
  logic             wd_hit_s;
  logic             tx_sel_s;
  logic             tmr_clr_s;
  logic             tmr_en_s;
  logic             tmr_tc_s;
  logic [CNT_W-1:0] tmr_tc_val_s;

  // Winner of an arbitration round among the current requests
  always_comb begin
    pick_s = REQ_CMD;
`ifdef UART_ARB_FIXED_PRIO_EN
    if (req[REQ_DATA]) begin
      pick_s = REQ_DATA;
    end else begin
      pick_s = REQ_CMD;
    end
`else
    if (req == 2'b11) begin
      pick_s = ~last_owner_q;
    end else if (req[REQ_DATA]) begin
      pick_s = REQ_DATA;
    end else begin
      pick_s = REQ_CMD;
    end
`endif
  end

  assign release_s = done[owner_q] | ~req[owner_q];
  assign wd_hit_s  = WD_EN & tmr_tc_s;
  assign tx_sel_s  = owner_q ? tx_in1 : tx_in0;

  // Next-state, grant and pulse logic
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    timeout_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_d = ST_GRANT;
          owner_d = pick_s;
          gnt_d   = pick_s ? 2'b10 : 2'b01;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A genuine release in the watchdog's last cycle is not a timeout
        if (release_s || wd_hit_s) begin
          state_d      = GUARD_EN ? ST_GUARD : ST_IDLE;
          gnt_d        = 2'b00;
          last_owner_d = owner_q;
          timeout_d    = ~release_s;
        end else begin
          state_d = ST_GRANT;
        end
      end
      ST_GUARD: begin
        if (tmr_tc_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GUARD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // Datapath next values: the line is forced idle from the release edge onward
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    tmr_clr_s    = (state_q == ST_IDLE) || (state_d != state_q);
    tmr_en_s     = (state_q != ST_IDLE);
    tmr_tc_val_s = (state_q == ST_GRANT) ? TIMEOUT_TC : GUARD_TC;
    if ((state_q == ST_GRANT) && (state_d == ST_GRANT)) begin
      tx_d = tx_sel_s;
    end else begin
      tx_d = 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 2'b00;
      owner_q      <= REQ_CMD;
      last_owner_q <= REQ_DATA;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      tx_q         <= tx_d;
    end
  end

  arb_cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clr_i    (tmr_clr_s),
    .en_i     (tmr_en_s),
    .tc_val_i (tmr_tc_val_s),
    .tc_o     (tmr_tc_s)
  );

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
  assign tx      = tx_q;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (GUARD_CYCLES=4, TIMEOUT_CYCLES=64).
// Directed scenarios followed by randomized requester traffic, all outputs
// compared every cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int GUARD = 4;
  localparam int TMO   = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] done;
  logic       tx_in0;
  logic       tx_in1;
  logic [1:0] gnt;
  logic       owner;
  logic       busy;
  logic       timeout;
  logic       tx;

  uart_tx_arbiter #(
    .GUARD_CYCLES   (GUARD),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (18)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .tx_in0  (tx_in0),
    .tx_in1  (tx_in1),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit tx_rand;

  // Reference model: who holds the line (-1 = nobody), how long it has held
  // it, how many quiet cycles remain, and the last requester served.
  int   m_holder;
  int   m_held;
  int   m_quiet;
  int   m_last;
  int   m_owner;
  logic m_to;
  logic m_tx;

  // Random requester agent state
  int left_cnt [2];
  bit drop_nxt [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_held   = 0;
    m_quiet  = 0;
    m_last   = 1;
    m_owner  = 0;
    m_to     = 1'b0;
    m_tx     = 1'b1;
  endtask

  function automatic int m_pick(input logic [1:0] r);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
`ifdef UART_ARB_FIXED_PRIO_EN
    return 1;
`else
    return 1 - m_last;
`endif
  endfunction

  task automatic m_release();
    m_last   = m_holder;
    m_holder = -1;
    m_quiet  = GUARD;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    logic [1:0] tin;
    tin  = {tx_in1, tx_in0};
    m_to = 1'b0;
    m_tx = 1'b1;
    if (m_holder >= 0) begin
      if (done[m_holder] || !req[m_holder]) begin
        m_release();
      end else if (m_held == TMO - 1) begin
        m_release();
        m_to = 1'b1;
      end else begin
        m_held++;
        m_tx = tin[m_holder];
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else if (req != 2'b00) begin
      m_holder = m_pick(req);
      m_held   = 0;
      m_owner  = m_holder;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [1:0] eg;
    logic       eb;
    eg = (m_holder < 0) ? 2'b00 : ((m_holder == 0) ? 2'b01 : 2'b10);
    eb = (m_holder >= 0) || (m_quiet > 0);
    check_val({tag, ".gnt"},     {30'b0, gnt},     {30'b0, eg});
    check_val({tag, ".owner"},   {31'b0, owner},   m_owner);
    check_val({tag, ".busy"},    {31'b0, busy},    {31'b0, eb});
    check_val({tag, ".timeout"}, {31'b0, timeout}, {31'b0, m_to});
    check_val({tag, ".tx"},      {31'b0, tx},      {31'b0, m_tx});
  endtask

  task automatic tick(input string tag);
    if (tx_rand) begin
      tx_in0 = 1'($urandom_range(0, 1));
      tx_in1 = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  // Pull reset low between edges, check it acts at once, release after an edge
  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    req     = 2'b00;
    done    = 2'b00;
    tx_in0  = 1'b1;
    tx_in1  = 1'b1;
    tx_rand = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst0");
    rst = 1'b1;

    // A: single requester, latency and tx forwarding
    repeat (3) tick("A.idle");
    req = 2'b01;
    tick("A.gnt");
    repeat (8) tick("A.tx");
    done = 2'b01;
    tick("A.done");
    done = 2'b00;
    req  = 2'b00;
    repeat (6) tick("A.guard");

    // B: tie from reset, stray done, alternation
    pulse_reset("B.rst");
    req = 2'b11;
    tick("B.first");
    repeat (3) tick("B.hold");
    done = 2'b10;
    tick("B.stray");
    done = 2'b00;
    repeat (3) tick("B.hold2");
    done = 2'b01;
    tick("B.done0");
    done = 2'b00;
    repeat (11) tick("B.alt1");
    done = 2'b10;
    tick("B.done1");
    done = 2'b00;
    repeat (8) tick("B.alt0");
    req = 2'b00;
    repeat (8) tick("B.drain");

    // C: watchdog revokes a silent owner, then it is granted again
    req = 2'b01;
    repeat (80) tick("C.wd");
    done = 2'b01;
    tick("C.done");
    done = 2'b00;
    req  = 2'b00;
    repeat (8) tick("C.drain");

    // D: done lands in the watchdog's last cycle
    req = 2'b01;
    tick("D.gnt");
    for (int k = 0; (k < TMO) && (m_held != TMO - 1); k++) tick("D.wait");
    done = 2'b01;
    tick("D.same");
    done = 2'b00;
    req  = 2'b00;
    repeat (8) tick("D.drain");

    // E: asynchronous reset in the middle of a frame
    tx_rand = 1'b0;
    tx_in0  = 1'b0;
    tx_in1  = 1'b1;
    req     = 2'b01;
    repeat (5) tick("E.frame");
    pulse_reset("E.rst");
    req = 2'b10;
    tick("E.regrant");
    tx_rand = 1'b1;
    repeat (5) tick("E.hold");
    req = 2'b00;
    repeat (8) tick("E.drain");

    // F: randomized requesters (some frames overrun the watchdog)
    for (int i = 0; i < 2; i++) begin
      left_cnt[i] = 0;
      drop_nxt[i] = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      done = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (drop_nxt[i]) begin
          req[i]      = 1'b0;
          drop_nxt[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i]      = 1'b1;
            left_cnt[i] = ($urandom_range(0, 9) == 0) ? 90 : int'($urandom_range(1, 20));
          end
        end else if (m_holder == i) begin
          if (left_cnt[i] > 0) left_cnt[i]--;
          if (left_cnt[i] == 0) begin
            if ($urandom_range(0, 3) == 0) begin
              req[i] = 1'b0;
            end else begin
              done[i]     = 1'b1;
              drop_nxt[i] = 1'b1;
            end
          end
        end else if ($urandom_range(0, 15) == 0) begin
          done[i] = 1'b1;
        end
      end
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single serial `tx` line between two frame sources: requester 0 (command sender) and requester 1 (data sender).
- Replaces the ad-hoc select-line mux with a request/grant handshake, round-robin fairness, an idle guard gap between frames and an ownership watchdog.
- Sits between the two serial senders and the top-level `tx` pin.

Parameters:
- GUARD_CYCLES, 16, clock cycles of forced idle-high after each release; 0 = no guard gap.
- TIMEOUT_CYCLES, 200000, max cycles one owner may hold the line; 0 = watchdog disabled.
- CNT_W, 18, width of the shared guard/timeout counter; must hold max(GUARD_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  2  req[i] high = requester i wants the line; held until done.
- done  in  2  done[i] one-cycle pulse: requester i finished its frame.
- tx_in0  in  1  serial output of requester 0.
- tx_in1  in  1  serial output of requester 1.
- gnt  out  2  one-hot grant; at most one bit set.
- owner  out  1  index of the current or last owner.
- busy  out  1  high in GRANT or GUARD.
- timeout  out  1  one-cycle pulse when the watchdog revokes a grant.
- tx  out  1  registered serial line; idle high.

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately, including mid-frame):
  - state=IDLE; gnt=00, owner=0, busy=0, timeout=0, tx=1.
  - last_owner=1, so requester 0 wins the first tie.
- States: IDLE, GRANT, GUARD.
- IDLE:
  - tx=1.
  - If any req is sampled high: GRANT next cycle, with gnt/owner registered in the same edge.
  - Both requesting: pick the requester that is not last_owner.
  - One requesting: pick that one.
  - Counter cleared.
- GRANT:
  - tx <= tx_in[owner], so tx lags the selected input by exactly 1 cycle.
  - Counter increments each cycle.
  - Release when done[owner]=1 or req[owner]=0 is sampled. Next cycle: gnt=00, last_owner=owner, then GUARD (or IDLE if GUARD_CYCLES=0).
  - Watchdog: if TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 with no release, force the same release path and pulse timeout for 1 cycle.
  - Release and timeout in the same cycle: release wins, no timeout pulse.
- GUARD:
  - tx=1; counter counts GUARD_CYCLES cycles, then IDLE.
  - Requests are not serviced here.
  - Minimum grant-to-grant gap after release is GUARD_CYCLES+1 cycles.
- Ignored inputs:
  - done from a non-owner.
  - done while in IDLE or GUARD.
- A requester still holding req after a timeout re-enters arbitration normally.
- busy = (state != IDLE), registered.
- owner holds its value through GUARD and IDLE.
- tx output comes straight from a flop; it never glitches on a grant change.

Optional Feature:
- UART_ARB_FIXED_PRIO_EN.
- Defined: requester 1 (data) always wins a simultaneous request; last_owner is ignored. The guard gap and watchdog are unchanged.
- Undefined: round-robin as described above.

Decomposition:
- Package uart_arb_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GUARD=2'd2;
  - requester index constants REQ_CMD=0, REQ_DATA=1;
  - the default CNT_W.
- One natural sub-module: arb_cycle_timer, a clearable up-counter with a terminal-count compare, shared by the guard and watchdog functions. The FSM, grant logic and tx mux stay in the top module.

Test Plan (GUARD_CYCLES=4, TIMEOUT_CYCLES=64):
- Reset with req=00 -> gnt=00, tx=1, busy=0. Then req=01 at cycle T -> gnt=01, busy=1 at T+1; tx follows tx_in0 from T+2.
- req=11 from reset -> gnt=01 first. After done[0], 4 guard cycles with tx=1, then gnt=10; then after done[1], gnt=01 (alternation).
- Owner 0 never pulses done for 64 cycles -> timeout pulses 1 cycle, gnt=00, 4 guard cycles, then re-grant to 0 if req=01.
- done[1] pulsed while gnt=01 -> no state change; done[0] and timeout in the same cycle -> timeout stays 0.
- rst pulled low mid-GRANT with tx_in0=0 -> tx=1 and gnt=00 immediately; after release, req=10 -> gnt=10 next cycle.
- With UART_ARB_FIXED_PRIO_EN, req=11 repeatedly -> gnt=10 on every arbitration.
